// File: rtl/mem_ctrl.sv
// Memory-stage RAM responder: executes single-word read/write requests on a
// byte-wide synchronous RAM, one byte lane per cycle, with busy/done status.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_r_enable_i,
  input  logic              ram_w_enable_i,
  input  logic [3:0]        ram_w_mask_i,
  input  logic [31:0]       ram_w_data_i,
  input  logic [31:0]       ram_addr_i,
  output logic [31:0]       ram_r_data_o,
  output logic              ram_busy_o,
  output logic              ram_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_LAST,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_inc;
  logic [ADDR_W-3:0] base_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [23:0]       rbuf_q;
  logic [31:0]       rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_dout_q;

  // Word-offset and out-of-range address bits are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W], ram_addr_i[1:0]};

  assign cnt_inc = cnt_q + 2'd1;

  // Outputs are registered alongside the state so the first byte slot is
  // already on the RAM port in the cycle right after the request is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ram_w_enable_i) begin
            state_q    <= S_WRITE;
            cnt_q      <= '0;
            base_q     <= ram_addr_i[ADDR_W-1:2];
            mask_q     <= ram_w_mask_i;
            wdata_q    <= ram_w_data_i;
            busy_q     <= 1'b1;
            mem_addr_q <= {ram_addr_i[ADDR_W-1:2], 2'b00};
            mem_wr_q   <= ram_w_mask_i[0];
            mem_dout_q <= ram_w_data_i[7:0];
          end else if (ram_r_enable_i) begin
            state_q    <= S_READ;
            cnt_q      <= '0;
            base_q     <= ram_addr_i[ADDR_W-1:2];
            busy_q     <= 1'b1;
            mem_addr_q <= {ram_addr_i[ADDR_W-1:2], 2'b00};
          end
        end
        S_WRITE: begin
          if (cnt_q == 2'd3) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q      <= cnt_inc;
            mem_addr_q <= {base_q, cnt_inc};
            mem_wr_q   <= mask_q[cnt_inc];
            mem_dout_q <= wdata_q[{cnt_inc, 3'b000} +: 8];
          end
        end
        S_READ: begin
          // RAM data lags its address by one cycle, so slot k lands at cnt k+1.
          case (cnt_q)
            2'd1:    rbuf_q[7:0]   <= mem_din_i;
            2'd2:    rbuf_q[15:8]  <= mem_din_i;
            2'd3:    rbuf_q[23:16] <= mem_din_i;
            default: ;
          endcase
          if (cnt_q == 2'd3) begin
            state_q <= S_READ_LAST;
          end else begin
            cnt_q      <= cnt_inc;
            mem_addr_q <= {base_q, cnt_inc};
          end
        end
        S_READ_LAST: begin
          rdata_q <= {mem_din_i, rbuf_q};
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_r_data_o = rdata_q;
  assign ram_busy_o   = busy_q;
  assign ram_done_o   = done_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_dout_o   = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model plus a word-level golden memory that
// predicts every bus cycle, status pulse and read word.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r_en, w_en;
  logic [3:0]    mask;
  logic [31:0]   wdata, addr;
  logic [31:0]   rdata;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [7:0]    mem_dout;
  bit   [7:0]    mem_din;

  bit [7:0]      ram  [0:(1<<AW)-1];
  bit [7:0]      gold [0:(1<<AW)-1];
  logic [31:0]   last_rd;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_r_enable_i (r_en),
    .ram_w_enable_i (w_en),
    .ram_w_mask_i   (mask),
    .ram_w_data_i   (wdata),
    .ram_addr_i     (addr),
    .ram_r_data_o   (rdata),
    .ram_busy_o     (busy),
    .ram_done_o     (done),
    .mem_addr_o     (mem_addr),
    .mem_wr_o       (mem_wr),
    .mem_dout_o     (mem_dout),
    .mem_din_i      (mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_dout;
    mem_din <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot(input logic [31:0] a, input int unsigned k);
    logic [31:0] s;
    s = a & 32'h0001_FFFC;
    return s + k;
  endfunction

  // Starts in an IDLE cycle; leaves the bench in the first IDLE cycle after DONE.
  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                          input bit both, input bit noise);
    int unsigned dones = 0;
    logic [31:0] junk;
    w_en = 1'b1; r_en = both; addr = a; mask = m; wdata = d;
    tick();
    junk = $urandom;
    w_en = 1'b0; r_en = noise; addr = junk; wdata = ~junk; mask = junk[7:4];
    for (int unsigned k = 0; k < 4; k++) begin
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_done", 32'(done), 32'd0);
      chk("wr_addr", 32'(mem_addr), slot(a, k));
      chk("wr_strobe", 32'(mem_wr), 32'(m[k]));
      if (m[k]) chk("wr_byte", 32'(mem_dout), (d >> (8*k)) & 32'hFF);
      dones += 32'(done);
      tick();
    end
    r_en = 1'b0;
    chk("wr_done_pulse", 32'(done), 32'd1);
    chk("wr_done_busy", 32'(busy), 32'd0);
    chk("wr_done_strobe", 32'(mem_wr), 32'd0);
    chk("wr_keeps_rdata", rdata, last_rd);
    dones += 32'(done);
    tick();
    chk("wr_idle_busy", 32'(busy), 32'd0);
    chk("wr_idle_done", 32'(done), 32'd0);
    dones += 32'(done);
    chk("wr_one_done", dones, 32'd1);
    for (int unsigned k = 0; k < 4; k++) begin
      logic [31:0] s;
      s = slot(a, k);
      if (m[k]) gold[s[AW-1:0]] = d[8*k +: 8];
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit hold);
    logic [31:0] exp;
    logic [31:0] s;
    for (int unsigned k = 0; k < 4; k++) begin
      s = slot(a, k);
      exp[8*k +: 8] = gold[s[AW-1:0]];
    end
    r_en = 1'b1; addr = a;
    tick();
    if (!hold) r_en = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_strobe", 32'(mem_wr), 32'd0);
      chk("rd_addr", 32'(mem_addr), slot(a, k));
      tick();
    end
    chk("rd_last_busy", 32'(busy), 32'd1);
    chk("rd_last_done", 32'(done), 32'd0);
    tick();
    chk("rd_done_pulse", 32'(done), 32'd1);
    chk("rd_done_busy", 32'(busy), 32'd0);
    chk("rd_data", rdata, exp);
    last_rd = exp;
    tick();
    chk("rd_not_reaccepted", 32'(busy), 32'd0);
    chk("rd_done_once", 32'(done), 32'd0);
    chk("rd_data_held", rdata, exp);
    r_en = 1'b0;
    tick();
    chk("rd_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rd, rm;
    rst_n = 1'b0; r_en = 1'b0; w_en = 1'b0; mask = '0; wdata = '0; addr = '0;
    last_rd = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobe", 32'(mem_wr), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_strobe", 32'(mem_wr), 32'd0);
      tick();
    end

    do_write(32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_write(32'h0000_0102, 4'b0100, 32'h5A5A_5A5A, 1'b0, 1'b0);
    do_write(32'h0000_0200, 4'b1111, 32'h4433_2211, 1'b0, 1'b0);
    do_read(32'h0000_0200, 1'b1);
    do_read(32'hFFFE_0104, 1'b0);
    // Both enables at once, then reads issued throughout the busy window.
    do_write(32'h0000_0200, 4'b0011, 32'h1234_ABCD, 1'b1, 1'b1);
    do_read(32'h0000_0200, 1'b0);

    // Reset during cycle 3 of a read.
    r_en = 1'b1; addr = 32'h0000_0104;
    tick();
    r_en = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_strobe", 32'(mem_wr), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    last_rd = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    do_read(32'h0000_0104, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rd = $urandom;
      rm = $urandom;
      ra[16:0] = 17'h1000 + 17'($urandom_range(0, 63));
      if (rm[8]) do_write(ra, rm[3:0], rd, rm[9], rm[10]);
      else       do_read(ra, rm[11]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the memory-stage RAM request interface.
- Accepts single-word read/write requests (address, 4-bit byte mask, 32-bit data) from the memory stage and executes them on a byte-wide synchronous external RAM, one byte per cycle.
- Returns `busy`/`done` status and the assembled read word.
- Sits between the memory stage and the external RAM port.

Parameters:
- ADDR_W, 17, width of the external byte address; request address bits above ADDR_W-1 are ignored.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ram_r_enable_i  input  1  read request from memory stage.
- ram_w_enable_i  input  1  write request from memory stage.
- ram_w_mask_i  input  4  byte-lane write mask; bit k enables byte k.
- ram_w_data_i  input  32  write data; byte k = bits [8k+7:8k].
- ram_addr_i  input  32  request byte address.
- ram_r_data_o  output  32  assembled read word.
- ram_busy_o  output  1  controller executing a request.
- ram_done_o  output  1  one-cycle completion pulse.
- mem_addr_o  output  ADDR_W  external RAM byte address.
- mem_wr_o  output  1  external RAM write strobe.
- mem_dout_o  output  8  external RAM write byte.
- mem_din_i  input  8  external RAM read byte; valid one cycle after its address is presented.

Behaviour:
- Reset is asynchronous and active-low (`rst_n` low):
  - state=IDLE, byte counter=0.
  - All outputs 0.
  - Any in-flight transaction is aborted and `mem_wr_o` drops immediately.
  - No `done` pulse is produced for the aborted request.
- Every output is a function of registered state only. There is no combinational path from the `ram_*_i` request inputs to any output, because the memory stage derives its requests combinationally from `busy`.
- States: IDLE, WRITE, READ, READ_LAST, DONE.
- IDLE:
  - Samples requests each edge; `busy`=0, `done`=0.
  - If `w_enable`=1: latch addr, mask and data; go to WRITE with cnt=0.
  - Else if `r_enable`=1: latch addr; go to READ with cnt=0.
  - Write has priority when both are asserted; the read is dropped, with no `done` for it.
- Requests arriving in any state other than IDLE are ignored. They are not queued.
- Byte address for slot k: `{addr_latched[ADDR_W-1:2], k[1:0]}`. This holds for both reads and writes; lane selection is done by the mask.
- WRITE (4 cycles, cnt 0..3):
  - `mem_addr_o` = slot cnt.
  - `mem_dout_o` = data byte cnt.
  - `mem_wr_o` = mask[cnt].
  - Latency is fixed at 4 cycles regardless of mask; a mask of 0000 still takes 4 cycles with no strobes.
  - cnt==3 → DONE.
- READ (4 cycles, cnt 0..3):
  - `mem_addr_o` = slot cnt, `mem_wr_o`=0.
  - From cnt≥1, capture `mem_din_i` into byte cnt-1 of the read buffer.
  - cnt==3 → READ_LAST.
- READ_LAST (1 cycle): capture `mem_din_i` into byte 3, then → DONE.
- DONE (1 cycle):
  - `done`=1, `busy`=0.
  - `ram_r_data_o` = buffer (valid this cycle; held until the next read completes).
  - Always → IDLE.
  - Requests are NOT sampled in DONE. This prevents re-accepting the same stalled request while the pipeline advances.
- `busy`=1 in WRITE, READ and READ_LAST; 0 in IDLE and DONE.
- Timing, taking the request-sampled edge as the end of cycle 0:
  - Write: `busy` cycles 1–4, `done` cycle 5.
  - Read: `busy` cycles 1–5, `done` cycle 6.
  - Minimum request-to-request spacing is one IDLE cycle after DONE.
- Byte order is little-endian: byte 0 is bits [7:0].
- Outside active WRITE/READ cycles: `mem_wr_o`=0 and `mem_addr_o` holds its last value. Only `mem_wr_o` matters to the RAM outside these cycles.
- `ram_r_data_o` is not modified by writes.

Test Plan:
- Reset/idle:
  - Stimulus: hold `rst_n`=0, then release.
  - Required: all outputs 0; state IDLE; no `mem_wr_o` activity with no requests.
- Word write:
  - Stimulus: one cycle of `w_enable`, addr=0x0000_0104, mask=1111, data=0xDEADBEEF.
  - Required: addrs 0x104..0x107 with bytes EF, BE, AD, DE and strobes 1,1,1,1 in cycles 1–4; `busy` 1–4; `done` in cycle 5.
- Byte write:
  - Stimulus: addr=0x0000_0102, mask=0100, data=0x5A5A5A5A.
  - Required: `mem_wr_o` high only in cycle 3 at addr 0x102 with byte 5A; 4-cycle latency preserved.
- Word read:
  - Stimulus: RAM 0x200..0x203 = 11,22,33,44; `r_enable` held high with addr=0x200.
  - Required: `ram_r_data_o`=0x44332211 with `done` in cycle 6; request not re-accepted in the DONE cycle; `busy`=0 in cycle 6.
- Priority and overlap:
  - Stimulus: both enables high in IDLE; then a new read request while busy.
  - Required: write executes alone; the read issued while busy is ignored, with exactly one `done` pulse.
- Reset mid-read:
  - Stimulus: assert `rst_n`=0 at cycle 3 of a read.
  - Required: `busy`, `done`, `mem_wr_o` and `ram_r_data_o` all 0 asynchronously; after release, a fresh read completes normally.
